// File: rtl/minirisc_pkg.sv
// Shared MiniRISC definitions: fetch state encoding and datapath widths.
package minirisc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    VALID    = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Bus acknowledge watchdog: 5-bit counter that flags when a read has waited too long.
module fetch_timer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [4:0] LAST = 5'(ACK_TIMEOUT - 1);

  logic [4:0] count;

  // Saturates so a timeout deferred by flush stays pending instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run && count != 5'd31) begin
      count <= count + 5'd1;
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/instr_fetch.sv
// MiniRISC instruction fetch stage: reads program memory over a req/ack bus into the IR.
module instr_fetch
  import minirisc_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_start,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               flush,
  output logic               pc_inc,
  output logic [ADDR_W-1:0]  prg_mem_addr,
  output logic               prg_mem_rd,
  input  logic [INSTR_W-1:0] prg_mem_din,
  input  logic               prg_mem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [ADDR_W-1:0]  ir_addr,
  output logic               busy,
  output logic               bus_err
);

  fetch_state_t       state, state_d;
  logic [ADDR_W-1:0]  addr_d, ir_addr_d;
  logic [INSTR_W-1:0] ir_d;
  logic               rd_d, bus_err_d;
  logic               timer_clr, timer_run, expired;

  fetch_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .run     (timer_run),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prg_mem_addr <= '0;
      prg_mem_rd   <= 1'b0;
      ir           <= '0;
      ir_addr      <= '0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_d;
      prg_mem_addr <= addr_d;
      prg_mem_rd   <= rd_d;
      ir           <= ir_d;
      ir_addr      <= ir_addr_d;
      bus_err      <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state;
    addr_d    = prg_mem_addr;
    rd_d      = prg_mem_rd;
    ir_d      = ir;
    ir_addr_d = ir_addr;
    bus_err_d = bus_err;
    pc_inc    = 1'b0;
    timer_clr = 1'b0;
    timer_run = 1'b0;

    unique case (state)
      IDLE: begin
        if (flush) begin
          bus_err_d = 1'b0;
        end else if (fetch_start && !bus_err) begin
          state_d   = WAIT_ACK;
          addr_d    = next_pc;
          rd_d      = 1'b1;
          timer_clr = 1'b1;
        end
      end

      WAIT_ACK: begin
        if (flush) begin
          bus_err_d = 1'b0;
          if (prg_mem_ack) begin
            state_d = IDLE;
            rd_d    = 1'b0;
          end else begin
            state_d   = DISCARD;
            timer_run = 1'b1;
          end
        end else if (prg_mem_ack) begin
          state_d   = VALID;
          ir_d      = prg_mem_din;
          ir_addr_d = prg_mem_addr;
          rd_d      = 1'b0;
          pc_inc    = 1'b1;
        end else if (expired) begin
          state_d   = IDLE;
          rd_d      = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          timer_run = 1'b1;
        end
      end

      VALID: begin
        if (flush) begin
          state_d   = IDLE;
          bus_err_d = 1'b0;
        end else if (ir_ready) begin
          if (fetch_start && !bus_err) begin
            state_d   = WAIT_ACK;
            addr_d    = next_pc;
            rd_d      = 1'b1;
            timer_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DISCARD: begin
        // A flush here keeps dropping the result, but a coincident ack still ends the bus cycle.
        if (prg_mem_ack) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          if (flush) bus_err_d = 1'b0;
        end else if (flush) begin
          bus_err_d = 1'b0;
          timer_run = 1'b1;
        end else if (expired) begin
          state_d   = IDLE;
          rd_d      = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          timer_run = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign ir_valid = (state == VALID);
  assign busy     = (state == WAIT_ACK) || (state == DISCARD);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a scoreboard of expected IR loads.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic [7:0]  next_pc;
  logic        flush;
  logic        pc_inc;
  logic [7:0]  prg_mem_addr;
  logic        prg_mem_rd;
  logic [15:0] prg_mem_din;
  logic        prg_mem_ack;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_addr;
  logic        busy;
  logic        bus_err;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .ACK_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_start  (fetch_start),
    .next_pc      (next_pc),
    .flush        (flush),
    .pc_inc       (pc_inc),
    .prg_mem_addr (prg_mem_addr),
    .prg_mem_rd   (prg_mem_rd),
    .prg_mem_din  (prg_mem_din),
    .prg_mem_ack  (prg_mem_ack),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .ir_addr      (ir_addr),
    .busy         (busy),
    .bus_err      (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_ir"}, 32'(ir), 32'(e.instr));
      chk({tag, "_ir_addr"}, 32'(ir_addr), 32'(e.addr));
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_start = 1'b0; next_pc = '0; flush = 1'b0;
    prg_mem_din = '0; prg_mem_ack = 1'b0; ir_ready = 1'b0;
    #12;
    chk("rst_rd", 32'(prg_mem_rd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    rst_n = 1'b1;
    cyc();

    // basic fetch, ack in the third read cycle
    next_pc = 8'h10; fetch_start = 1'b1;
    #1 chk("basic_pc_inc_idle", 32'(pc_inc), 0);
    cyc();
    fetch_start = 1'b0;
    chk("basic_rd", 32'(prg_mem_rd), 1);
    chk("basic_addr", 32'(prg_mem_addr), 32'h10);
    chk("basic_busy", 32'(busy), 1);
    cyc();
    chk("basic_rd2", 32'(prg_mem_rd), 1);
    chk("basic_no_pc_inc", 32'(pc_inc), 0);
    cyc();
    prg_mem_ack = 1'b1; prg_mem_din = 16'hA5C3;
    sb.push_back('{instr: 16'hA5C3, addr: 8'h10});
    #1 chk("basic_pc_inc", 32'(pc_inc), 1);
    cyc();
    prg_mem_ack = 1'b0;
    #1 chk("basic_pc_inc_done", 32'(pc_inc), 0);
    chk("basic_rd_low", 32'(prg_mem_rd), 0);
    chk("basic_ir_valid", 32'(ir_valid), 1);
    sb_check("basic");
    // stray ack while VALID must be ignored
    prg_mem_ack = 1'b1; prg_mem_din = 16'h1234;
    #1 chk("valid_ack_pc_inc", 32'(pc_inc), 0);
    cyc();
    prg_mem_ack = 1'b0;
    chk("valid_hold", 32'(ir_valid), 1);
    chk("valid_ir_stable", 32'(ir), 32'hA5C3);

    // back-to-back fetch with minimum latency
    ir_ready = 1'b1; fetch_start = 1'b1; next_pc = 8'h11;
    cyc();
    ir_ready = 1'b0; fetch_start = 1'b0;
    chk("b2b_rd", 32'(prg_mem_rd), 1);
    chk("b2b_addr", 32'(prg_mem_addr), 32'h11);
    chk("b2b_ir_valid", 32'(ir_valid), 0);
    prg_mem_ack = 1'b1; prg_mem_din = 16'h5A3C;
    sb.push_back('{instr: 16'h5A3C, addr: 8'h11});
    #1 chk("b2b_pc_inc", 32'(pc_inc), 1);
    cyc();
    prg_mem_ack = 1'b0;
    chk("b2b_ir_valid2", 32'(ir_valid), 1);
    sb_check("b2b");
    ir_ready = 1'b1;
    cyc();
    ir_ready = 1'b0;
    chk("consume_ir_valid", 32'(ir_valid), 0);
    chk("consume_busy", 32'(busy), 0);

    // flush one cycle after start
    next_pc = 8'h20; fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 1);
    chk("flush_rd_held", 32'(prg_mem_rd), 1);
    chk("flush_ir_valid", 32'(ir_valid), 0);
    cyc();
    chk("flush_rd_held2", 32'(prg_mem_rd), 1);
    prg_mem_ack = 1'b1; prg_mem_din = 16'hFFFF;
    #1 chk("flush_no_pc_inc", 32'(pc_inc), 0);
    cyc();
    prg_mem_ack = 1'b0;
    chk("flush_rd_done", 32'(prg_mem_rd), 0);
    chk("flush_idle", 32'(busy), 0);
    chk("flush_ir_kept", 32'(ir), 32'h5A3C);
    chk("flush_ir_valid2", 32'(ir_valid), 0);

    // flush coincident with ack
    next_pc = 8'h30; fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    prg_mem_ack = 1'b1; prg_mem_din = 16'hBEEF; flush = 1'b1;
    #1 chk("flack_pc_inc", 32'(pc_inc), 0);
    cyc();
    prg_mem_ack = 1'b0; flush = 1'b0;
    chk("flack_busy", 32'(busy), 0);
    chk("flack_rd", 32'(prg_mem_rd), 0);
    chk("flack_ir_valid", 32'(ir_valid), 0);
    chk("flack_ir", 32'(ir), 32'h5A3C);

    // timeout with ACK_TIMEOUT=4
    next_pc = 8'h40; fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_rd_high", 32'(prg_mem_rd), 1);
      chk("to_no_err", 32'(bus_err), 0);
      cyc();
    end
    chk("to_rd_low", 32'(prg_mem_rd), 0);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_busy", 32'(busy), 0);
    next_pc = 8'h41; fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    chk("to_start_blocked", 32'(prg_mem_rd), 0);
    chk("to_start_blocked_busy", 32'(busy), 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("to_err_cleared", 32'(bus_err), 0);

    // 0xFF is fetched like any other address, then async reset mid-read
    next_pc = 8'hFF; fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    chk("wrap_addr", 32'(prg_mem_addr), 32'hFF);
    chk("wrap_rd", 32'(prg_mem_rd), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", 32'(prg_mem_rd), 0);
    chk("arst_ir_valid", 32'(ir_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_addr", 32'(prg_mem_addr), 0);
    chk("arst_ir", 32'(ir), 0);
    chk("arst_ir_addr", 32'(ir_addr), 0);
    chk("arst_pc_inc", 32'(pc_inc), 0);
    #1 rst_n = 1'b1;
    prg_mem_ack = 1'b1; prg_mem_din = 16'hDEAD;
    #1 chk("late_ack_pc_inc", 32'(pc_inc), 0);
    cyc();
    prg_mem_ack = 1'b0;
    chk("late_ack_ir_valid", 32'(ir_valid), 0);
    chk("late_ack_ir", 32'(ir), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
